// File: rtl/ika87ad_opfetch.sv
// Opcode fetch and prefix tracker in front of the opcode decoder.
// Pulls opcode bytes over a request/valid handshake, folds the five prefix
// bytes into a 3-bit opcode page, injects the hardware-interrupt opcode at
// instruction boundaries and turns skipped instructions into a flagged NOP.
//
// Handshake: a byte is consumed in a cycle where o_FETCH_REQ and i_BYTE_VALID
// are both high; o_FETCH_REQ is low in the cycle after every consume, so each
// request yields exactly one byte and a second-byte request always restarts
// from a clean low.
module ika87ad_opfetch #(
  parameter logic [7:0] HARDI_OP = 8'h73,
  parameter logic [7:0] NOP_OP   = 8'h00
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST,
  input  logic       i_NEXT,
  input  logic       i_SKIP_FLAG,
  input  logic       i_IRQ_PEND,
  output logic       o_FETCH_REQ,
  input  logic       i_BYTE_VALID,
  input  logic [7:0] i_BYTE,
  output logic       o_PC_INC,
  output logic [7:0] o_OPCODE,
  output logic [2:0] o_OPCODE_PAGE,
  output logic       o_OP_VALID,
  output logic       o_SKIPPED,
  output logic       o_INTACK,
  output logic       o_BUSY
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH1   = 2'd1,
    S_FETCH2   = 2'd2,
    S_DISPATCH = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       fetch_req_q, fetch_req_d;
  logic       pc_inc_q, pc_inc_d;
  logic       op_valid_q, op_valid_d;
  logic       intack_q, intack_d;
  logic       skipped_q, skipped_d;
  logic       skip_q, skip_d;
  logic [7:0] opcode_q, opcode_d;
  logic [2:0] page_q, page_d;
  logic [2:0] pend_page_q, pend_page_d;

  logic       consume;
  logic [2:0] byte_page;
  logic       do_disp;
  logic [2:0] disp_page;

  assign consume = fetch_req_q & i_BYTE_VALID;

  // Prefix byte to opcode page; zero means "not a prefix".
  always_comb begin
    byte_page = 3'd0;
    case (i_BYTE)
      8'h48:   byte_page = 3'd1;
      8'h60:   byte_page = 3'd2;
      8'h64:   byte_page = 3'd3;
      8'h70:   byte_page = 3'd4;
      8'h74:   byte_page = 3'd5;
      default: byte_page = 3'd0;
    endcase
  end

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_d     = state_q;
    fetch_req_d = 1'b0;
    pc_inc_d    = 1'b0;
    op_valid_d  = 1'b0;
    intack_d    = 1'b0;
    skipped_d   = skipped_q;
    skip_d      = skip_q;
    opcode_d    = opcode_q;
    page_d      = page_q;
    pend_page_d = pend_page_q;
    do_disp     = 1'b0;
    disp_page   = 3'd0;

    case (state_q)
      S_IDLE, S_DISPATCH: begin
        state_d = S_IDLE;
        if (i_NEXT) begin
          if (i_SKIP_FLAG) begin
            // Skip wins; a pending interrupt waits for the next boundary.
            skip_d      = 1'b1;
            fetch_req_d = 1'b1;
            state_d     = S_FETCH1;
          end else if (i_IRQ_PEND) begin
            opcode_d   = HARDI_OP;
            page_d     = 3'd0;
            skipped_d  = 1'b0;
            intack_d   = 1'b1;
            op_valid_d = 1'b1;
            state_d    = S_DISPATCH;
          end else begin
            skip_d      = 1'b0;
            fetch_req_d = 1'b1;
            state_d     = S_FETCH1;
          end
        end
      end

      S_FETCH1: begin
        if (consume) begin
          pc_inc_d = 1'b1;
          if (byte_page != 3'd0) begin
            // Prefix: remember the page, request the real opcode next.
            pend_page_d = byte_page;
            state_d     = S_FETCH2;
          end else begin
            do_disp   = 1'b1;
            disp_page = 3'd0;
          end
        end else begin
          fetch_req_d = 1'b1;
        end
      end

      S_FETCH2: begin
        if (consume) begin
          // Second byte is always the opcode, even if it looks like a prefix.
          pc_inc_d  = 1'b1;
          do_disp   = 1'b1;
          disp_page = pend_page_q;
        end else begin
          fetch_req_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (do_disp) begin
      state_d    = S_DISPATCH;
      op_valid_d = 1'b1;
      if (skip_q) begin
        opcode_d  = NOP_OP;
        page_d    = 3'd0;
        skipped_d = 1'b1;
      end else begin
        opcode_d  = i_BYTE;
        page_d    = disp_page;
        skipped_d = 1'b0;
      end
    end
  end

  // State and registered outputs; reset drops any partial prefix.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state_q     <= S_IDLE;
      fetch_req_q <= 1'b0;
      pc_inc_q    <= 1'b0;
      op_valid_q  <= 1'b0;
      intack_q    <= 1'b0;
      skipped_q   <= 1'b0;
      skip_q      <= 1'b0;
      opcode_q    <= 8'h00;
      page_q      <= 3'd0;
      pend_page_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      fetch_req_q <= fetch_req_d;
      pc_inc_q    <= pc_inc_d;
      op_valid_q  <= op_valid_d;
      intack_q    <= intack_d;
      skipped_q   <= skipped_d;
      skip_q      <= skip_d;
      opcode_q    <= opcode_d;
      page_q      <= page_d;
      pend_page_q <= pend_page_d;
    end
  end

  assign o_FETCH_REQ   = fetch_req_q;
  assign o_PC_INC      = pc_inc_q;
  assign o_OPCODE      = opcode_q;
  assign o_OPCODE_PAGE = page_q;
  assign o_OP_VALID    = op_valid_q;
  assign o_SKIPPED     = skipped_q;
  assign o_INTACK      = intack_q;
  assign o_BUSY        = (state_q != S_IDLE);

endmodule

// File: doc/ika87ad_opfetch.md
Name: ika87ad_opfetch

Overview:
- Opcode fetch and prefix tracker sitting directly upstream of the opcode decoder (opcode + page → microcode ROM start address).
- Pulls instruction bytes from the bus interface with a request/valid handshake.
- Recognises the five prefix bytes and folds them into a 3-bit opcode page.
- Injects the hardware-interrupt opcode at instruction boundaries and marks skipped instructions; presents a stable {opcode, page} pair plus a valid pulse to the decoder/sequencer.

Parameters:
- HARDI_OP, 8'h73, opcode presented on page 0 when an interrupt is injected.
- NOP_OP, 8'h00, opcode presented on page 0 for a skipped instruction.

Ports:
- i_EMUCLK  in  1  system clock; all logic is on the rising edge.
- i_RST  in  1  reset, synchronous, active-high.
- i_NEXT  in  1  sequencer requests the next instruction (instruction boundary).
- i_SKIP_FLAG  in  1  PSW skip flag, sampled when i_NEXT is accepted.
- i_IRQ_PEND  in  1  maskable/non-maskable interrupt pending, sampled when i_NEXT is accepted.
- o_FETCH_REQ  out  1  request one opcode byte at the current PC.
- i_BYTE_VALID  in  1  bus returns a byte; consumed when o_FETCH_REQ=1 in the same cycle.
- i_BYTE  in  8  returned byte.
- o_PC_INC  out  1  one-cycle pulse per byte consumed.
- o_OPCODE  out  8  final opcode byte to the decoder.
- o_OPCODE_PAGE  out  3  opcode page to the decoder.
- o_OP_VALID  out  1  one-cycle pulse: o_OPCODE/o_OPCODE_PAGE are new.
- o_SKIPPED  out  1  qualifies o_OP_VALID: the instruction was skipped.
- o_INTACK  out  1  one-cycle pulse, coincident with o_OP_VALID, on interrupt injection.
- o_BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE; o_OPCODE=8'h00; o_OPCODE_PAGE=3'd0; o_FETCH_REQ, o_PC_INC, o_OP_VALID, o_SKIPPED, o_INTACK all 0. Reset mid-fetch abandons the fetch; the partial prefix is discarded.
- States: IDLE, FETCH1, FETCH2, DISPATCH.
- i_NEXT is accepted in IDLE or DISPATCH and ignored in FETCH1/FETCH2.
- On acceptance:
  - If i_SKIP_FLAG=1: skip_r←1 and go to FETCH1. Skip has priority; the interrupt is deferred.
  - Else if i_IRQ_PEND=1: o_OPCODE←HARDI_OP, page←0, o_INTACK←1, go to DISPATCH. No byte is fetched and o_PC_INC is not pulsed.
  - Else: skip_r←0 and go to FETCH1.
- FETCH1: o_FETCH_REQ=1, held until i_BYTE_VALID (any number of wait cycles). On the consume cycle, o_PC_INC pulses the next cycle. Then:
  - Prefix map: 48→page 1, 60→2, 64→3, 70→4, 74→5. On a prefix, latch the page and go to FETCH2.
  - Any other byte: page 0, o_OPCODE←byte, go to DISPATCH.
- FETCH2: same handshake. o_OPCODE←byte; page is unchanged; go to DISPATCH. A prefix value here is an ordinary opcode and is not re-prefixed.
- Skipped instruction: both bytes are consumed normally (1 or 2 o_PC_INC pulses). At DISPATCH, o_OPCODE=NOP_OP, page=0, o_SKIPPED=1.
- DISPATCH (one cycle): o_OP_VALID=1. Outputs hold until the next dispatch. Next state is IDLE, or FETCH1/DISPATCH if i_NEXT arrives in that cycle.
- Latency:
  - i_NEXT at cycle n → o_FETCH_REQ at n+1.
  - Byte consumed at cycle m → o_OP_VALID at m+1 (single byte) or at m2+1 (after the second byte at m2).
  - Interrupt: o_OP_VALID at n+1.
- No interrupt is taken between a prefix and its second byte.
- o_FETCH_REQ deasserts the cycle after a consume, so each request yields exactly one byte.

Test Plan:
- Reset, then i_NEXT with byte 0x54 returned at zero wait → o_FETCH_REQ at n+1; o_OP_VALID at n+2 with opcode 0x54, page 0; one o_PC_INC.
- i_NEXT; bytes 0x70 then 0x6A, with 3 wait cycles before each → page 4, opcode 0x6A; two o_PC_INC pulses; exactly one o_OP_VALID.
- Each prefix 48/60/64/70/74 followed by 0x48 → pages 1/2/3/4/5; opcode 0x48 in every case, never a third fetch.
- i_NEXT with i_IRQ_PEND=1 → opcode 0x73, page 0, o_INTACK and o_OP_VALID at n+1; o_FETCH_REQ never asserted.
- i_NEXT with i_SKIP_FLAG=1 and i_IRQ_PEND=1; bytes 0x60, 0x91 → two o_PC_INC pulses; opcode 0x00, page 0, o_SKIPPED=1; no o_INTACK.
- i_RST asserted in FETCH2 after prefix 0x74 → next cycle IDLE with all outputs at reset values; the following i_NEXT with byte 0x21 gives page 0.
